row_slider: RTL

Gameplay core that sits directly downstream of the level FSM. It consumes `speed_count` and `num_blocks` and slides the active row of blocks left and right across the board at the commanded frame rate. On a player press it freezes the row and judges its overlap with the row below. It returns the `next_signal` verdict that the level FSM samples, and exports row and stack masks to the renderer.

---
 rtl/row_slider.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/row_slider.sv
// rtl/row_slider.sv - slides the active block row, freezes it on a press and judges overlap with the stack
module row_slider #(
    parameter int BOARD_W  = 8,
    parameter int MAX_ROWS = 15
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic               go,
    input  logic [10:0]        speed_count,
    input  logic [3:0]         num_blocks,
    output logic [BOARD_W-1:0] row_mask,
    output logic [BOARD_W-1:0] stack_mask,
    output logic [3:0]         row_y,
    output logic               next_signal,
    output logic               game_over,
    output logic               win
);

    typedef enum logic [1:0] {LOAD, SLIDE, HOLD, RESULT} state_t;

    localparam logic [3:0] FULL_W  = 4'(BOARD_W);
    localparam logic [3:0] TOP_ROW = 4'(MAX_ROWS - 1);

    state_t             state, state_nx;
    logic [3:0]         width, width_nx;
    logic [3:0]         pos, pos_nx;
    logic               dir_left, dir_left_nx;
    logic [10:0]        frame_cnt, frame_cnt_nx;
    logic [BOARD_W-1:0] stack_nx;
    logic [3:0]         row_y_nx;
    logic               next_nx, game_over_nx, win_nx;
    logic               restart, restart_nx;
    logic               go_prev;

    logic [2*BOARD_W-1:0] run_bits;
    logic [BOARD_W-1:0]   overlap;
    logic [10:0]          step_limit;
    logic [3:0]           req_width, kept_width;

    function automatic logic [3:0] clamp_width(input logic [3:0] n);
        if (n == 4'd0) return 4'd1;
        if (n > FULL_W) return FULL_W;
        return n;
    endfunction

    function automatic logic [3:0] popcount(input logic [BOARD_W-1:0] m);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < BOARD_W; i++) c = c + {3'b000, m[i]};
        return c;
    endfunction

    assign run_bits   = ((2*BOARD_W)'(1) << width) - (2*BOARD_W)'(1);
    assign row_mask   = BOARD_W'(run_bits << pos);
    assign overlap    = row_mask & stack_mask;
    assign step_limit = (speed_count == 11'd0) ? 11'd0 : speed_count - 11'd1;
    assign req_width  = clamp_width(num_blocks);
    assign kept_width = (popcount(overlap) < req_width) ? popcount(overlap) : req_width;

    always_comb begin
        state_nx     = state;
        width_nx     = width;
        pos_nx       = pos;
        dir_left_nx  = dir_left;
        frame_cnt_nx = frame_cnt;
        stack_nx     = stack_mask;
        row_y_nx     = row_y;
        next_nx      = next_signal;
        restart_nx   = restart;
        game_over_nx = 1'b0;
        win_nx       = 1'b0;
        case (state)
            LOAD: begin
                width_nx     = req_width;
                pos_nx       = 4'd0;
                dir_left_nx  = 1'b0;
                frame_cnt_nx = 11'd0;
                state_nx     = SLIDE;
            end
            SLIDE: begin
                // A press wins over a step due in the same cycle
                if (go && !go_prev) begin
                    state_nx = HOLD;
                end else if (frame_tick) begin
                    if (frame_cnt >= step_limit) begin
                        frame_cnt_nx = 11'd0;
                        if (width != FULL_W) begin
                            if (!dir_left) begin
                                if (pos + width == FULL_W) begin
                                    dir_left_nx = 1'b1;
                                    pos_nx      = pos - 4'd1;
                                end else begin
                                    pos_nx = pos + 4'd1;
                                end
                            end else if (pos == 4'd0) begin
                                dir_left_nx = 1'b0;
                                pos_nx      = pos + 4'd1;
                            end else begin
                                pos_nx = pos - 4'd1;
                            end
                        end
                    end else begin
                        frame_cnt_nx = frame_cnt + 11'd1;
                    end
                end
            end
            HOLD: begin
                if (!go) begin
                    next_nx  = |overlap;
                    state_nx = RESULT;
                    if (|overlap) begin
                        stack_nx = overlap;
                        width_nx = kept_width;
                        if (row_y == TOP_ROW) begin
                            win_nx     = 1'b1;
                            restart_nx = 1'b1;
                        end else begin
                            row_y_nx = row_y + 4'd1;
                        end
                    end else begin
                        game_over_nx = 1'b1;
                        restart_nx   = 1'b1;
                    end
                end
            end
            RESULT: begin
                pos_nx       = 4'd0;
                dir_left_nx  = 1'b0;
                frame_cnt_nx = 11'd0;
                if (restart) begin
                    stack_nx   = '1;
                    row_y_nx   = 4'd0;
                    width_nx   = 4'd0;
                    restart_nx = 1'b0;
                    state_nx   = LOAD;
                end else begin
                    state_nx = SLIDE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= LOAD;
            width       <= 4'd0;
            pos         <= 4'd0;
            dir_left    <= 1'b0;
            frame_cnt   <= 11'd0;
            stack_mask  <= '1;
            row_y       <= 4'd0;
            next_signal <= 1'b0;
            game_over   <= 1'b0;
            win         <= 1'b0;
            restart     <= 1'b0;
            go_prev     <= 1'b1; // a button held through reset must not fire
        end else begin
            state       <= state_nx;
            width       <= width_nx;
            pos         <= pos_nx;
            dir_left    <= dir_left_nx;
            frame_cnt   <= frame_cnt_nx;
            stack_mask  <= stack_nx;
            row_y       <= row_y_nx;
            next_signal <= next_nx;
            game_over   <= game_over_nx;
            win         <= win_nx;
            restart     <= restart_nx;
            go_prev     <= go;
        end
    end

endmodule
